pipe_stage_buf: RTL and testbench

Parametrised elastic pipeline stage register carrying instruction, PC, a generic payload and the register-write control bit between two pipeline stages (IF/ID, ID/EX, EX/MEM, MEM/WB). It adds a valid/ready handshake, optional two-entry skid buffering, synchronous flush and a saturating stall counter. Downstream stages see a guaranteed NOP (instr 0, regwrite 0) whenever the stage holds no valid entry.

---
 rtl/pipe_stage_buf.sv | 141 ++++++++++++++
 tb/tb_pipe_stage_buf.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_buf.sv
// Elastic pipeline stage register (instr/PC/payload/regwrite) with valid/ready handshake,
// optional two-entry skid buffer, synchronous flush and a saturating stall counter.
module pipe_stage_buf #(
  parameter int unsigned PAYLOAD_W = 96,
  parameter logic [31:0] PC_RESET  = 32'h00003000,
  parameter int unsigned SKID      = 1,
  parameter int unsigned CNT_W     = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 flush,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [31:0]          in_instr,
  input  logic [31:0]          in_pc,
  input  logic [PAYLOAD_W-1:0] in_payload,
  input  logic                 in_regwrite,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [31:0]          out_instr,
  output logic [31:0]          out_pc,
  output logic [PAYLOAD_W-1:0] out_payload,
  output logic                 out_regwrite,
  output logic [CNT_W-1:0]     stall_cnt
);

  logic                 w_accept;
  logic                 w_pop;
  logic                 w_load_in;
  logic                 w_load_skid;

  logic [31:0]          w_skid_instr;
  logic [31:0]          w_skid_pc;
  logic [PAYLOAD_W-1:0] w_skid_payload;
  logic                 w_skid_regwrite;

  logic                 r_main_valid;
  logic [31:0]          r_main_instr;
  logic [31:0]          r_main_pc;
  logic [PAYLOAD_W-1:0] r_main_payload;
  logic                 r_main_regwrite;
  logic [CNT_W-1:0]     r_stall_cnt;

  assign w_accept = in_valid & in_ready;
  assign w_pop    = r_main_valid & out_ready;

  generate
    if (SKID != 0) begin : g_skid
      logic                 w_main_free;
      logic                 w_to_skid;
      logic                 r_skid_valid;
      logic [31:0]          r_skid_instr;
      logic [31:0]          r_skid_pc;
      logic [PAYLOAD_W-1:0] r_skid_payload;
      logic                 r_skid_regwrite;

      // Skid always drains into main before new input, which keeps the order FIFO.
      assign w_main_free = ~r_main_valid | out_ready;
      assign w_load_skid = w_main_free & r_skid_valid;
      assign w_load_in   = w_main_free & ~r_skid_valid & w_accept;
      assign w_to_skid   = ~w_main_free & w_accept;
      assign in_ready    = ~r_skid_valid;

      assign w_skid_instr    = r_skid_instr;
      assign w_skid_pc       = r_skid_pc;
      assign w_skid_payload  = r_skid_payload;
      assign w_skid_regwrite = r_skid_regwrite;

      always_ff @(posedge clk) begin
        if (reset) begin
          r_skid_valid    <= 1'b0;
          r_skid_instr    <= '0;
          r_skid_pc       <= '0;
          r_skid_payload  <= '0;
          r_skid_regwrite <= 1'b0;
        end else if (flush) begin
          r_skid_valid <= 1'b0;
        end else if (w_to_skid) begin
          r_skid_valid    <= 1'b1;
          r_skid_instr    <= in_instr;
          r_skid_pc       <= in_pc;
          r_skid_payload  <= in_payload;
          r_skid_regwrite <= in_regwrite;
        end else if (w_load_skid) begin
          r_skid_valid <= 1'b0;
        end
      end
    end else begin : g_no_skid
      assign w_load_skid     = 1'b0;
      assign w_load_in       = w_accept;
      assign in_ready        = ~r_main_valid | out_ready;
      assign w_skid_instr    = '0;
      assign w_skid_pc       = '0;
      assign w_skid_payload  = '0;
      assign w_skid_regwrite = 1'b0;
    end
  endgenerate

  // Data fields only change on a load so PC/payload keep their last value after pop or flush.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_main_valid    <= 1'b0;
      r_main_instr    <= '0;
      r_main_pc       <= PC_RESET;
      r_main_payload  <= '0;
      r_main_regwrite <= 1'b0;
    end else if (flush) begin
      r_main_valid <= 1'b0;
    end else if (w_load_skid) begin
      r_main_valid    <= 1'b1;
      r_main_instr    <= w_skid_instr;
      r_main_pc       <= w_skid_pc;
      r_main_payload  <= w_skid_payload;
      r_main_regwrite <= w_skid_regwrite;
    end else if (w_load_in) begin
      r_main_valid    <= 1'b1;
      r_main_instr    <= in_instr;
      r_main_pc       <= in_pc;
      r_main_payload  <= in_payload;
      r_main_regwrite <= in_regwrite;
    end else if (w_pop) begin
      r_main_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_stall_cnt <= '0;
    end else if (r_main_valid & ~out_ready & ~(&r_stall_cnt)) begin
      r_stall_cnt <= r_stall_cnt + 1'b1;
    end
  end

  assign out_valid    = r_main_valid;
  assign out_instr    = r_main_valid ? r_main_instr : 32'd0;
  assign out_regwrite = r_main_valid & r_main_regwrite;
  assign out_pc       = r_main_pc;
  assign out_payload  = r_main_payload;
  assign stall_cnt    = r_stall_cnt;

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Bench for pipe_stage_buf: three configurations (skid, no skid, 4-bit counter) checked against
// a capacity-limited FIFO reference model under directed and random stimulus.
module tb_pipe_stage_buf;
  localparam int unsigned PW  = 96;
  localparam logic [31:0] PCR = 32'h00003000;

  typedef struct packed {
    logic [31:0]   instr;
    logic [31:0]   pc;
    logic [PW-1:0] pay;
    logic          rw;
  } ent_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset, flush, in_valid, in_regwrite;
  logic [31:0]   in_instr, in_pc;
  logic [PW-1:0] in_payload;

  logic          ordy [3];
  logic          ov   [3];
  logic          ir   [3];
  logic          orw  [3];
  logic [31:0]   oi   [3];
  logic [31:0]   opc  [3];
  logic [PW-1:0] opay [3];
  logic [15:0]   sc   [3];
  logic [3:0]    sc_sat;

  assign sc[2] = {12'd0, sc_sat};

  pipe_stage_buf #(.PAYLOAD_W(PW), .PC_RESET(PCR), .SKID(1), .CNT_W(16)) u_skid (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(ir[0]),
    .in_instr(in_instr), .in_pc(in_pc), .in_payload(in_payload), .in_regwrite(in_regwrite),
    .out_valid(ov[0]), .out_ready(ordy[0]), .out_instr(oi[0]), .out_pc(opc[0]),
    .out_payload(opay[0]), .out_regwrite(orw[0]), .stall_cnt(sc[0])
  );

  pipe_stage_buf #(.PAYLOAD_W(PW), .PC_RESET(PCR), .SKID(0), .CNT_W(16)) u_noskid (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(ir[1]),
    .in_instr(in_instr), .in_pc(in_pc), .in_payload(in_payload), .in_regwrite(in_regwrite),
    .out_valid(ov[1]), .out_ready(ordy[1]), .out_instr(oi[1]), .out_pc(opc[1]),
    .out_payload(opay[1]), .out_regwrite(orw[1]), .stall_cnt(sc[1])
  );

  pipe_stage_buf #(.PAYLOAD_W(PW), .PC_RESET(PCR), .SKID(1), .CNT_W(4)) u_sat (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(ir[2]),
    .in_instr(in_instr), .in_pc(in_pc), .in_payload(in_payload), .in_regwrite(in_regwrite),
    .out_valid(ov[2]), .out_ready(ordy[2]), .out_instr(oi[2]), .out_pc(opc[2]),
    .out_payload(opay[2]), .out_regwrite(orw[2]), .stall_cnt(sc_sat)
  );

  // Reference model: a FIFO of capacity cap[d]; head is the visible entry.
  ent_t          m_ent [3][2];
  int            m_sz  [3];
  int            m_cnt [3];
  logic [31:0]   m_pc  [3];
  logic [PW-1:0] m_pay [3];
  int            cap   [3] = '{2, 1, 2};
  int            cmax  [3] = '{65535, 65535, 15};

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input int d, input logic [127:0] obs,
                     input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s[%0d]: got %0h want %0h", tag, d, obs, exp);
    end
  endtask

  function automatic bit m_rdy(input int d);
    if (cap[d] == 2) return m_sz[d] < 2;
    return (m_sz[d] == 0) || ordy[d];
  endfunction

  task automatic check_all();
    for (int d = 0; d < 3; d++) begin
      bit   v = m_sz[d] > 0;
      ent_t h = m_ent[d][0];
      chk("out_valid", d, ov[d], v);
      chk("in_ready", d, ir[d], m_rdy(d));
      chk("out_instr", d, oi[d], v ? h.instr : 32'd0);
      chk("out_regwrite", d, orw[d], v ? h.rw : 1'b0);
      chk("out_pc", d, opc[d], m_pc[d]);
      chk("out_payload", d, opay[d], m_pay[d]);
      chk("stall_cnt", d, sc[d], m_cnt[d]);
    end
  endtask

  task automatic model_update();
    for (int d = 0; d < 3; d++) begin
      bit   acc = in_valid && m_rdy(d);
      bit   pop = (m_sz[d] > 0) && ordy[d];
      ent_t e   = '{instr: in_instr, pc: in_pc, pay: in_payload, rw: in_regwrite};
      if (reset) begin
        m_sz[d]  = 0;
        m_cnt[d] = 0;
        m_pc[d]  = PCR;
        m_pay[d] = '0;
      end else begin
        if (m_sz[d] > 0 && !ordy[d] && m_cnt[d] < cmax[d]) m_cnt[d]++;
        if (flush) begin
          m_sz[d] = 0;
        end else begin
          if (pop) begin
            m_ent[d][0] = m_ent[d][1];
            m_sz[d]--;
          end
          if (acc) begin
            m_ent[d][m_sz[d]] = e;
            m_sz[d]++;
          end
        end
        if (m_sz[d] > 0) begin
          m_pc[d]  = m_ent[d][0].pc;
          m_pay[d] = m_ent[d][0].pay;
        end
      end
    end
  endtask

  // Inputs are driven at the falling edge; outputs are checked 1 time unit later.
  task automatic step(input bit do_check);
    #1;
    if (do_check) check_all();
    model_update();
    @(negedge clk);
  endtask

  task automatic drive(input bit v, input logic [31:0] instr, input bit rw);
    in_valid    = v;
    in_instr    = instr;
    in_pc       = $urandom;
    in_payload  = {$urandom, $urandom, $urandom};
    in_regwrite = rw;
  endtask

  task automatic set_rdy(input bit a, input bit b, input bit c);
    ordy[0] = a;
    ordy[1] = b;
    ordy[2] = c;
  endtask

  initial begin
    for (int d = 0; d < 3; d++) begin
      m_sz[d]  = 0;
      m_cnt[d] = 0;
      m_pc[d]  = PCR;
      m_pay[d] = '0;
    end
    reset = 1'b1;
    flush = 1'b0;
    set_rdy(1, 1, 1);
    drive(1, 32'h8C010004, 1);
    step(0);
    step(1);
    reset = 1'b0;

    // Streaming at full throughput
    drive(1, 32'h8C010004, 1); step(1);
    drive(1, 32'h00221820, 1); step(1);
    drive(1, 32'hAC030008, 0); step(1);
    drive(0, 32'h0, 0);        step(1);
    step(1);

    // Backpressure, then long stall to saturate the 4-bit counter
    set_rdy(0, 0, 0);
    drive(1, 32'h11111111, 1); step(1);
    drive(1, 32'h22222222, 0); step(1);
    drive(1, 32'h33333333, 1); step(1);
    drive(0, 32'h0, 0);
    for (int i = 0; i < 20; i++) step(1);
    chk("bp_in_ready", 0, ir[0], 1'b0);
    chk("sat_cnt", 2, sc[2], 16'd15);

    // Drain
    set_rdy(1, 1, 1);
    for (int i = 0; i < 4; i++) step(1);

    // Fill skid, then flush with a concurrent push
    set_rdy(0, 0, 0);
    drive(1, 32'h44444444, 1); step(1);
    drive(1, 32'h55555555, 1); step(1);
    flush = 1'b1;
    drive(1, 32'h66666666, 1); step(1);
    flush = 1'b0;
    drive(0, 32'h0, 0);
    chk("flush_valid", 0, ov[0], 1'b0);
    chk("flush_ready", 0, ir[0], 1'b1);
    step(1);
    step(1);

    // Single-register mode: ready follows out_ready combinationally when full
    set_rdy(0, 0, 0);
    drive(1, 32'h77777777, 1); step(1);
    drive(1, 32'h88888888, 1); step(1);
    chk("noskid_ready_lo", 1, ir[1], 1'b0);
    set_rdy(1, 1, 1);
    #1;
    chk("noskid_ready_hi", 1, ir[1], 1'b1);
    step(1);
    drive(0, 32'h0, 0);
    step(1);

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      reset = ($urandom_range(0, 99) == 0);
      flush = ($urandom_range(0, 15) == 0);
      set_rdy($urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, $urandom_range(0, 3) != 0);
      drive($urandom_range(0, 2) != 0, $urandom, $urandom_range(0, 1) == 1);
      step(1);
    end
    reset = 1'b0;
    flush = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
